// File: rtl/cache_ctrl_dm_if.sv
// CPU-side request port and memory-side port of the direct-mapped cache controller.
interface cache_ctrl_dm_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;
    logic                  busy;
    logic                  hit;
    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [15:0]           miss_count;

    // Environment side: CPU plus main memory.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_ready, busy, hit, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        input  miss_count
    );

    // Controller side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_ready, busy, hit, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        output miss_count
    );
endinterface

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller with block refill
// from a 1-cycle-latency word-addressed memory.
module cache_ctrl_dm #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INDEX_BITS  = 6,
    parameter int unsigned OFFSET_BITS = 2
) (
    input logic            clk,
    input logic            rst,
    cache_ctrl_dm_if.slave bus
);
    localparam int unsigned TagBits = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned Lines   = 2 ** INDEX_BITS;
    localparam int unsigned Words   = 2 ** (INDEX_BITS + OFFSET_BITS);
    localparam logic [OFFSET_BITS-1:0] LastOff = '1;

    typedef enum logic [2:0] {StIdle, StCompare, StRefill, StFillLast, StWrite} state_e;

    state_e                  state_q, state_d;
    logic [OFFSET_BITS-1:0]  cnt_q, cnt_d;
    logic                    req_we_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic [DATA_WIDTH-1:0]   req_wdata_q;
    logic [Lines-1:0]        valid_q;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                    ready_q, ready_d;
    logic                    hit_q, hit_d;
    logic                    wr_hit_q, wr_hit_d;
    logic [15:0]             miss_count_q;

    logic [TagBits-1:0]      tag_mem  [Lines];
    logic [DATA_WIDTH-1:0]   data_mem [Words];

    logic [TagBits-1:0]      req_tag;
    logic [INDEX_BITS-1:0]   req_idx;
    logic [OFFSET_BITS-1:0]  req_off;
    logic                    lookup_hit;
    logic                    data_we;
    logic [INDEX_BITS+OFFSET_BITS-1:0] data_waddr;
    logic [DATA_WIDTH-1:0]   data_wdata;
    logic                    set_valid, clr_valid, miss_inc;

    assign req_tag    = req_addr_q[ADDR_WIDTH-1 -: TagBits];
    assign req_idx    = req_addr_q[OFFSET_BITS +: INDEX_BITS];
    assign req_off    = req_addr_q[OFFSET_BITS-1:0];
    assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cpu_rdata_d    = cpu_rdata_q;
        ready_d        = 1'b0;
        hit_d          = 1'b0;
        wr_hit_d       = wr_hit_q;
        data_we        = 1'b0;
        data_waddr     = '0;
        data_wdata     = '0;
        set_valid      = 1'b0;
        clr_valid      = 1'b0;
        miss_inc       = 1'b0;
        bus.mem_rd_en  = 1'b0;
        bus.mem_wr_en  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        unique case (state_q)
            StIdle: if (bus.cpu_req) state_d = StCompare;
            StCompare: begin
                if (req_we_q) begin
                    wr_hit_d = lookup_hit;
                    state_d  = StWrite;
                end else if (lookup_hit) begin
                    cpu_rdata_d = data_mem[{req_idx, req_off}];
                    ready_d     = 1'b1;
                    hit_d       = 1'b1;
                    state_d     = StIdle;
                end else begin
                    // Invalidate up front so an abandoned refill never leaves a stale-tag hit.
                    cnt_d     = '0;
                    clr_valid = 1'b1;
                    state_d   = StRefill;
                end
            end
            StRefill: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = {req_tag, req_idx, cnt_q};
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q != '0) begin
                    data_we    = 1'b1;
                    data_waddr = {req_idx, cnt_q - 1'b1};
                    data_wdata = bus.mem_rdata;
                end
                if (cnt_q == LastOff) state_d = StFillLast;
            end
            StFillLast: begin
                data_we     = 1'b1;
                data_waddr  = {req_idx, LastOff};
                data_wdata  = bus.mem_rdata;
                set_valid   = 1'b1;
                cpu_rdata_d = (req_off == LastOff) ? bus.mem_rdata : data_mem[{req_idx, req_off}];
                ready_d     = 1'b1;
                miss_inc    = 1'b1;
                state_d     = StIdle;
            end
            StWrite: begin
                bus.mem_wr_en = 1'b1;
                bus.mem_addr  = req_addr_q;
                bus.mem_wdata = req_wdata_q;
                ready_d       = 1'b1;
                if (wr_hit_q) begin
                    data_we    = 1'b1;
                    data_waddr = {req_idx, req_off};
                    data_wdata = req_wdata_q;
                    hit_d      = 1'b1;
                end else begin
                    miss_inc = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            valid_q      <= '0;
            cpu_rdata_q  <= '0;
            ready_q      <= 1'b0;
            hit_q        <= 1'b0;
            wr_hit_q     <= 1'b0;
            miss_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            ready_q     <= ready_d;
            hit_q       <= hit_d;
            wr_hit_q    <= wr_hit_d;
            if (state_q == StIdle && bus.cpu_req) begin
                req_we_q    <= bus.cpu_we;
                req_addr_q  <= bus.cpu_addr;
                req_wdata_q <= bus.cpu_wdata;
            end
            if (clr_valid) valid_q[req_idx] <= 1'b0;
            if (set_valid) valid_q[req_idx] <= 1'b1;
            if (miss_inc && miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_mem[data_waddr] <= data_wdata;
        if (set_valid) tag_mem[req_idx] <= req_tag;
    end

    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ready  = ready_q;
    assign bus.hit        = hit_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.miss_count = miss_count_q;
endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Self-checking bench: directed plan steps plus random traffic against a cache/memory model.
module tb_cache_ctrl_dm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_dm_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    cache_ctrl_dm #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .INDEX_BITS (6),
        .OFFSET_BITS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Main memory with registered 1-cycle read data.
    logic [31:0] ram [65536];
    always @(posedge clk) begin
        if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Reference model: golden memory image plus per-line valid/tag.
    logic [31:0] ref_mem [65536];
    bit          ref_valid [64];
    logic [7:0]  ref_tag [64];
    int          ref_miss;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata;
    logic        last_hit;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
        int          idx;
        logic        exp_hit;
        int          lat;
        int          exp_lat;
        int          rd_n;
        int          wr_n;
        bit          rd_ok;
        bit          both;
        bit          busy_ok;
        logic [15:0] wr_addr;
        logic [31:0] wr_data;
        logic [15:0] base;
        idx     = int'(addr[7:2]);
        exp_hit = ref_valid[idx] && (ref_tag[idx] == addr[15:8]);
        exp_lat = we ? 3 : (exp_hit ? 2 : 7);
        base    = {addr[15:2], 2'b00};
        lat = -1; rd_n = 0; wr_n = 0; rd_ok = 1; both = 0; busy_ok = 1;
        wr_addr = '0; wr_data = '0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) bus.cpu_req = 1'b0;
            if (bus.mem_rd_en && bus.mem_wr_en) both = 1;
            if (bus.mem_rd_en) begin
                // Miss refill reads the block in order, one word per cycle from cycle 2.
                if (bus.mem_addr !== base + 16'(rd_n) || c != rd_n + 2) rd_ok = 0;
                rd_n++;
            end
            if (bus.mem_wr_en) begin
                wr_n++; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata;
            end
            if (bus.cpu_ready) begin
                lat = c; last_rdata = bus.cpu_rdata; last_hit = bus.hit;
                if (bus.busy) busy_ok = 0;
                break;
            end else if (!bus.busy) busy_ok = 0;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("hit", 64'(last_hit), 64'(exp_hit));
        check("rd_wr_exclusive", 64'(both), 64'd0);
        check("busy", 64'(busy_ok), 64'd1);
        if (we) begin
            check("wr_count", 64'(wr_n), 64'd1);
            check("wr_addr", 64'(wr_addr), 64'(addr));
            check("wr_data", 64'(wr_data), 64'(wdata));
            check("wr_no_reads", 64'(rd_n), 64'd0);
            ref_mem[addr] = wdata;
            if (!exp_hit) ref_miss++;
        end else begin
            check("rd_count", 64'(rd_n), exp_hit ? 64'd0 : 64'd4);
            check("rd_addrs", 64'(rd_ok), 64'd1);
            check("rdata", 64'(last_rdata), 64'(ref_mem[addr]));
            if (!exp_hit) begin
                ref_miss++; ref_valid[idx] = 1; ref_tag[idx] = addr[15:8];
            end
        end
        check("miss_count", 64'(bus.miss_count), 64'(ref_miss > 65535 ? 65535 : ref_miss));
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  tags [4];
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
            ref_mem[i] = ram[i];
        end
        for (int i = 0; i < 64; i++) ref_valid[i] = 0;
        ref_miss = 0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ready", 64'(bus.cpu_ready), 64'd0);
        check("rst_rdata", 64'(bus.cpu_rdata), 64'd0);
        check("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_miss_count", 64'(bus.miss_count), 64'd0);

        for (int i = 0; i < 4; i++) do_req(1'b1, 16'h0120 + 16'(i), 32'hA0 + 32'(i));
        check("plan_miss4", 64'(bus.miss_count), 64'd4);
        do_req(1'b0, 16'h0123, '0);
        check("plan_rd_a3", 64'(last_rdata), 64'hA3);
        check("plan_miss5", 64'(bus.miss_count), 64'd5);
        do_req(1'b0, 16'h0121, '0);
        check("plan_rd_a1", 64'(last_rdata), 64'hA1);
        check("plan_hit_a1", 64'(last_hit), 64'd1);
        do_req(1'b1, 16'h0122, 32'h1234_5678);
        do_req(1'b0, 16'h0122, '0);
        check("plan_rd_upd", 64'(last_rdata), 64'h1234_5678);
        do_req(1'b1, 16'h0040, 32'hDEAD_BEEF);
        do_req(1'b0, 16'h0040, '0);
        check("plan_rd_dead", 64'(last_rdata), 64'hDEAD_BEEF);
        do_req(1'b0, 16'h0100, '0);
        do_req(1'b0, 16'h4100, '0);
        do_req(1'b0, 16'h0100, '0);
        check("plan_conflict", 64'(bus.miss_count), 64'd10);
        do_req(1'b0, 16'hFFFE, '0);
        do_req(1'b0, 16'hFFFF, '0);

        // Random traffic over a few lines and conflicting tags.
        tags[0] = 8'h01; tags[1] = 8'h41; tags[2] = 8'hFF;
        for (int n = 0; n < 200; n++) begin
            tags[3] = 8'($urandom);
            a = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 3) * 21), 2'($urandom)};
            do_req($urandom_range(0, 2) == 0, a, $urandom);
        end

        // Reset during the third refill read.
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h3A0D;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_in_refill", 64'(bus.mem_rd_en), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_busy", 64'(bus.busy), 64'd0);
        check("mid_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check("mid_ready", 64'(bus.cpu_ready), 64'd0);
        check("mid_miss_count", 64'(bus.miss_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) ref_valid[i] = 0;
        ref_miss = 0;
        do_req(1'b0, 16'h3A0D, '0);
        check("mid_refetch_miss", 64'(last_hit), 64'd0);
        do_req(1'b0, 16'h3A0C, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
